sa_global: RTL
==============

# sa_global

Global switch-allocation stage of the NoC router. Takes the single winning request that each input port's local allocator presents, arbitrates per output port among all input ports using a QoS filter and round-robin, gates grants on downstream buffer credits, and drives the read enables back to the input ports. It also drives the registered crossbar select for the switch-traversal stage.

## Interface
- `INPUT_PORT_NUM`, default 5: number of input ports (requesters).
- `OUTPUT_PORT_NUM`, default 6: number of output ports; equals `rvh_noc_pkg::OUTPUT_PORT_NUMBER`.
- `CREDIT_DEPTH`, default 4: downstream buffer slots per output port.
- `INPUT_IDX_W`, default `$clog2(INPUT_PORT_NUM)`: input index width (1 when `INPUT_PORT_NUM` is 1).
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `sa_local_vld_to_sa_global_i` in `INPUT_PORT_NUM*OUTPUT_PORT_NUM`: slice `[i*OUTPUT_PORT_NUM +: OUTPUT_PORT_NUM]` is input i's output-port request. It is zero or one-hot.
- `sa_local_qos_value_i` in `INPUT_PORT_NUM*4`: 4-bit QoS value per input.
- `credit_return_i` in `OUTPUT_PORT_NUM`: one freed downstream slot per asserted bit.
- `inport_read_enable_sa_stage_o` out `INPUT_PORT_NUM`: input i won this cycle. Combinational.
- `st_vld_o` out `OUTPUT_PORT_NUM`: registered per-output traversal valid.
- `st_inport_idx_o` out `OUTPUT_PORT_NUM*INPUT_IDX_W`: registered crossbar select per output.
- `credit_avail_o` out `OUTPUT_PORT_NUM`: registered, meaning credit count > 0.

## Operation
- For each output o:
  - Candidates are inputs i with request bit o set.
  - The QoS filter keeps only candidates whose QoS equals the maximum QoS among the candidates. Ties are all kept.
- Round-robin:
  - `rr_ptr_q[o]` is `INPUT_IDX_W` bits, reset 0.
  - The winner is the first filtered candidate found scanning indices `rr_ptr_q[o]`, `rr_ptr_q[o]+1`, … modulo `INPUT_PORT_NUM`.
  - The scan wraps at `INPUT_PORT_NUM`, not at 2^`INPUT_IDX_W`.
- A grant for o requires winner present AND `credit_cnt_q[o] != 0`. With zero credit there is no grant, the pointer holds, and the candidates see no read enable.
- On a grant to winner w: `rr_ptr_q[o] <= (w == INPUT_PORT_NUM-1) ? 0 : w+1`.
- Credit counter:
  - `credit_cnt_q[o]` is `$clog2(CREDIT_DEPTH+1)` bits, reset `CREDIT_DEPTH`.
  - Next value = count − grant + return.
  - Grant and return in the same cycle leave the count unchanged.
  - A return while the count is at `CREDIT_DEPTH` saturates. A simulation-only assertion fires in that case.
- `inport_read_enable_sa_stage_o[i]` = OR over o of (grant_o AND winner_o == i). At most one output can grant a given input because requests are one-hot.
- Registered outputs: `st_vld_o[o] <= grant_o` and `st_inport_idx_o[o] <= winner_o`. The index holds its previous value when there is no grant.

## Timing
- Request to read enable: 0 cycles, purely combinational.
- Request to `st_vld_o` / `st_inport_idx_o`: 1 cycle.
- Credit and pointer updates take effect at the next clock edge. A grant in cycle t with count 1 blocks output o in cycle t+1 unless a credit return also occurs in cycle t.
- `credit_avail_o` reflects `credit_cnt_q` and lags its update by 0 cycles after the edge.
- Reset values:
  - `st_vld_o` = 0, `st_inport_idx_o` = 0, `credit_avail_o` = all ones (when `CREDIT_DEPTH` > 0).
  - All pointers 0, all counts `CREDIT_DEPTH`.
- A reset asserted mid-operation restores these values immediately and asynchronously. Credits in flight are discarded; the downstream side is reset together with this block.
- A non-one-hot request vector is illegal. Behaviour is undefined and a simulation-only assertion flags it.

## Configuration
- `SA_GLOBAL_QOS_EN` defined: QoS filter active as described above.
- Not defined: the filter is bypassed, all candidates go straight to round-robin, and `sa_local_qos_value_i` is unused.

## Structure
- `rvh_noc_pkg` holds `QoS_Value_Width` (4) and `OUTPUT_PORT_NUMBER` (6). The package gains `SA_GLOBAL_CREDIT_DEPTH` (4).
- One sub-module, `sa_global_outport_arb`, instantiated `OUTPUT_PORT_NUM` times. Each instance contains the QoS filter, round-robin pointer, credit counter, and registered traversal outputs for one output port. The top level only transposes the request matrix and ORs the read enables.

## Test plan
- Inputs 0, 2, 3 request output 1 at equal QoS, continuously, with credits always returned the next cycle:
  - Grants go 0, 2, 3, 0.
  - `st_inport_idx_o[1]` follows one cycle later.
- Inputs 1 and 4 request output 0 with QoS 2 and QoS 7:
  - Input 4 wins every cycle while QoS is enabled.
  - With `SA_GLOBAL_QOS_EN` undefined, the grants alternate 1, 4.
- Input 2 requests output 5 for 6 cycles with no credit returns:
  - Grants in the first 4 cycles only.
  - `credit_avail_o[5]` = 0 from cycle 4.
  - Read enable stays low in cycles 4–5.
- Count 1 on output 3, with a grant and `credit_return_i[3]` in the same cycle:
  - Count stays 1 and the next cycle grants again.
  - Separately, a return at full count holds the count at 4 and fires the assertion.
- Pointer wrap: input 4 wins output 2, so the pointer goes to 0. Inputs 0 and 3 then request and input 0 wins.
- `rstn` pulsed low mid-stream:
  - All outputs go to reset values asynchronously.
  - After release, arbitration restarts from pointer 0 with full credits.

Source files
------------

// File: rtl/rvh_noc_pkg.sv
// ============================================================================
// Module   : rvh_noc_pkg
// Brief    : Shared NoC router constants and types.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rvh_noc_pkg;

  localparam int QoS_Value_Width        = 4;
  localparam int OUTPUT_PORT_NUMBER     = 6;
  localparam int SA_GLOBAL_CREDIT_DEPTH = 4;

  typedef logic [QoS_Value_Width-1:0] qos_t;

endpackage

`default_nettype wire

// File: rtl/sa_global_outport_arb.sv
// ============================================================================
// Module   : sa_global_outport_arb
// Brief    : Per-output QoS filter, round-robin arbiter, credit counter and
//            registered traversal outputs. QoS filter enabled by SA_GLOBAL_QOS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sa_global_outport_arb
  import rvh_noc_pkg::*;
#(
  parameter int INPUT_PORT_NUM = 5,
  parameter int CREDIT_DEPTH   = SA_GLOBAL_CREDIT_DEPTH,
  parameter int INPUT_IDX_W    = (INPUT_PORT_NUM > 1) ? $clog2(INPUT_PORT_NUM) : 1,
  parameter int CNT_W          = (CREDIT_DEPTH > 0) ? $clog2(CREDIT_DEPTH + 1) : 1
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic [INPUT_PORT_NUM-1:0]                 i_req,
  input  logic [INPUT_PORT_NUM*QoS_Value_Width-1:0] i_qos,
  input  logic                                      i_credit_return,
  output logic                                      o_grant,
  output logic [INPUT_IDX_W-1:0]                    o_winner,
  output logic                                      o_st_vld,
  output logic [INPUT_IDX_W-1:0]                    o_st_inport_idx,
  output logic                                      o_credit_avail
);

  localparam logic [CNT_W-1:0]       C_CNT_FULL = CNT_W'(CREDIT_DEPTH);
  localparam logic [INPUT_IDX_W-1:0] C_IDX_LAST = INPUT_IDX_W'(INPUT_PORT_NUM - 1);

  logic [INPUT_IDX_W-1:0]    r_rr_ptr;
  logic [CNT_W-1:0]          r_credit_cnt;
  logic                      r_st_vld;
  logic [INPUT_IDX_W-1:0]    r_st_idx;
  logic                      r_credit_avail;

  logic [INPUT_PORT_NUM-1:0] w_cand;
  logic                      w_found;
  logic [INPUT_IDX_W-1:0]    w_winner;
  logic                      w_grant;
  logic [INPUT_IDX_W-1:0]    w_rr_ptr_nxt;
  logic [CNT_W-1:0]          w_credit_cnt_nxt;

`ifdef SA_GLOBAL_QOS_EN
  qos_t w_max_qos;

  always_comb begin
    w_max_qos = '0;
    for (int i = 0; i < INPUT_PORT_NUM; i++) begin
      if (i_req[i] && (i_qos[i*QoS_Value_Width +: QoS_Value_Width] > w_max_qos)) begin
        w_max_qos = i_qos[i*QoS_Value_Width +: QoS_Value_Width];
      end
    end
    w_cand = '0;
    for (int i = 0; i < INPUT_PORT_NUM; i++) begin
      w_cand[i] = i_req[i] && (i_qos[i*QoS_Value_Width +: QoS_Value_Width] == w_max_qos);
    end
  end
`else
  logic w_qos_unused;

  assign w_cand       = i_req;
  assign w_qos_unused = ^i_qos;
`endif

  // Scan wraps at INPUT_PORT_NUM, not at the power of two of the pointer width.
  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int k = 0; k < INPUT_PORT_NUM; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= INPUT_PORT_NUM) begin
        idx = idx - INPUT_PORT_NUM;
      end
      if (!w_found && w_cand[idx]) begin
        w_found  = 1'b1;
        w_winner = INPUT_IDX_W'(idx);
      end
    end
  end

  assign w_grant      = w_found && (r_credit_cnt != '0);
  assign w_rr_ptr_nxt = (w_winner == C_IDX_LAST) ? '0 : (w_winner + 1'b1);

  always_comb begin
    w_credit_cnt_nxt = r_credit_cnt;
    if (w_grant && !i_credit_return) begin
      w_credit_cnt_nxt = r_credit_cnt - 1'b1;
    end else if (!w_grant && i_credit_return && (r_credit_cnt != C_CNT_FULL)) begin
      w_credit_cnt_nxt = r_credit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr       <= '0;
      r_credit_cnt   <= C_CNT_FULL;
      r_st_vld       <= 1'b0;
      r_st_idx       <= '0;
      r_credit_avail <= (CREDIT_DEPTH > 0);
    end else begin
      r_credit_cnt   <= w_credit_cnt_nxt;
      r_credit_avail <= (w_credit_cnt_nxt != '0);
      r_st_vld       <= w_grant;
      if (w_grant) begin
        r_rr_ptr <= w_rr_ptr_nxt;
        r_st_idx <= w_winner;
      end
    end
  end

  assign o_grant         = w_grant;
  assign o_winner        = w_winner;
  assign o_st_vld        = r_st_vld;
  assign o_st_inport_idx = r_st_idx;
  assign o_credit_avail  = r_credit_avail;

`ifndef SYNTHESIS
  a_credit_overflow : assert property (@(posedge clk) disable iff (!rstn)
    !(i_credit_return && !w_grant && (r_credit_cnt == C_CNT_FULL)));
`endif

endmodule

`default_nettype wire

// File: rtl/sa_global.sv
// ============================================================================
// Module   : sa_global
// Brief    : Global switch allocator: per-output arbitration, credit gating and
//            read-enable generation. Optional QoS filter via SA_GLOBAL_QOS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sa_global
  import rvh_noc_pkg::*;
#(
  parameter int INPUT_PORT_NUM  = 5,
  parameter int OUTPUT_PORT_NUM = OUTPUT_PORT_NUMBER,
  parameter int CREDIT_DEPTH    = SA_GLOBAL_CREDIT_DEPTH,
  parameter int INPUT_IDX_W     = (INPUT_PORT_NUM > 1) ? $clog2(INPUT_PORT_NUM) : 1
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic [INPUT_PORT_NUM*OUTPUT_PORT_NUM-1:0] sa_local_vld_to_sa_global_i,
  input  logic [INPUT_PORT_NUM*4-1:0]               sa_local_qos_value_i,
  input  logic [OUTPUT_PORT_NUM-1:0]                credit_return_i,
  output logic [INPUT_PORT_NUM-1:0]                 inport_read_enable_sa_stage_o,
  output logic [OUTPUT_PORT_NUM-1:0]                st_vld_o,
  output logic [OUTPUT_PORT_NUM*INPUT_IDX_W-1:0]    st_inport_idx_o,
  output logic [OUTPUT_PORT_NUM-1:0]                credit_avail_o
);

  logic [OUTPUT_PORT_NUM-1:0] w_grant;
  logic [INPUT_IDX_W-1:0]     w_winner [OUTPUT_PORT_NUM];

  for (genvar o = 0; o < OUTPUT_PORT_NUM; o++) begin : g_outport
    logic [INPUT_PORT_NUM-1:0] w_req_col;

    for (genvar i = 0; i < INPUT_PORT_NUM; i++) begin : g_col
      assign w_req_col[i] = sa_local_vld_to_sa_global_i[i*OUTPUT_PORT_NUM + o];
    end

    sa_global_outport_arb #(
      .INPUT_PORT_NUM (INPUT_PORT_NUM),
      .CREDIT_DEPTH   (CREDIT_DEPTH),
      .INPUT_IDX_W    (INPUT_IDX_W)
    ) u_arb (
      .clk             (clk),
      .rstn            (rstn),
      .i_req           (w_req_col),
      .i_qos           (sa_local_qos_value_i),
      .i_credit_return (credit_return_i[o]),
      .o_grant         (w_grant[o]),
      .o_winner        (w_winner[o]),
      .o_st_vld        (st_vld_o[o]),
      .o_st_inport_idx (st_inport_idx_o[o*INPUT_IDX_W +: INPUT_IDX_W]),
      .o_credit_avail  (credit_avail_o[o])
    );
  end

  // One-hot requests guarantee each input is granted by at most one output.
  always_comb begin
    inport_read_enable_sa_stage_o = '0;
    for (int o = 0; o < OUTPUT_PORT_NUM; o++) begin
      for (int i = 0; i < INPUT_PORT_NUM; i++) begin
        if (w_grant[o] && (w_winner[o] == INPUT_IDX_W'(i))) begin
          inport_read_enable_sa_stage_o[i] = 1'b1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  for (genvar i = 0; i < INPUT_PORT_NUM; i++) begin : g_req_chk
    a_req_onehot : assert property (@(posedge clk) disable iff (!rstn)
      $onehot0(sa_local_vld_to_sa_global_i[i*OUTPUT_PORT_NUM +: OUTPUT_PORT_NUM]));
  end
`endif

endmodule

`default_nettype wire
